// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - shared types and constants for the tournament direction predictor
package bp_fe_pkg;

  localparam int lhist_width_gp = 8;

  localparam logic [1:0] ctr_init_gp     = 2'b01;
  localparam logic [1:0] chooser_init_gp = 2'b10;

  typedef enum logic {e_clear, e_run} e_tourn_state;

  // Snapshot handed out with each prediction and returned untouched at training time.
  typedef struct packed {
    logic [lhist_width_gp-1:0] lhist;
    logic [1:0]                lctr;
    logic [1:0]                gctr;
    logic [1:0]                cctr;
  } bp_fe_tourn_meta_s;

endpackage

// File: rtl/bp_fe_sat_ctr2.sv
// rtl/bp_fe_sat_ctr2.sv - 2-bit saturating counter next-value logic
module bp_fe_sat_ctr2 (
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i && (ctr_i != 2'b11))
      ctr_o = ctr_i + 2'd1;
    else if (!up_i && (ctr_i != 2'b00))
      ctr_o = ctr_i - 2'd1;
  end

endmodule

// File: rtl/bp_fe_tournament_bht.sv
// rtl/bp_fe_tournament_bht.sv - tournament (local + gshare + chooser) direction predictor
// Optional miss counters enabled by defining BP_FE_TOURN_STATS_EN.
module bp_fe_tournament_bht
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int ghist_width_p = 8,
  parameter int lidx_width_p  = 6,
  parameter int lhist_width_p = lhist_width_gp,
  parameter int gidx_width_p  = 9,
  parameter int cidx_width_p  = 9,
  localparam int meta_width_lp = $bits(bp_fe_tourn_meta_s)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  output logic                     init_done_o,
  input  logic                     r_v_i,
  input  logic [vaddr_width_p-1:0] r_addr_i,
  input  logic [ghist_width_p-1:0] r_ghist_i,
  output logic                     pred_v_o,
  output logic                     pred_o,
  output logic [meta_width_lp-1:0] r_meta_o,
  input  logic                     w_v_i,
  input  logic [vaddr_width_p-1:0] w_addr_i,
  input  logic [ghist_width_p-1:0] w_ghist_i,
  input  logic [meta_width_lp-1:0] w_meta_i,
  input  logic                     w_taken_i,
  output logic                     w_yumi_o,
  output logic [31:0]              stat_lmiss_o,
  output logic [31:0]              stat_gmiss_o,
  output logic [31:0]              stat_tmiss_o
);

  // The clear sweep must cover the deepest table; shallower tables simply wrap.
  localparam int lw_lp = (lidx_width_p > lhist_width_p) ? lidx_width_p : lhist_width_p;
  localparam int gw_lp = (gidx_width_p > cidx_width_p) ? gidx_width_p : cidx_width_p;
  localparam int sweep_width_lp = (lw_lp > gw_lp) ? lw_lp : gw_lp;

  e_tourn_state              state_r;
  logic [sweep_width_lp-1:0] idx_r;
  logic                      init_done_r;
  logic                      clearing, wr_en;

  logic [lhist_width_p-1:0] lht [2**lidx_width_p];
  logic [1:0]               lpt [2**lhist_width_p];
  logic [1:0]               gpt [2**gidx_width_p];
  logic [1:0]               cht [2**cidx_width_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_clear;
      idx_r       <= '0;
      init_done_r <= 1'b0;
    end else if (state_r == e_clear) begin
      idx_r <= idx_r + 1'b1;
      if (idx_r == '1) begin
        state_r     <= e_run;
        init_done_r <= 1'b1;
      end
    end
  end

  assign clearing    = (state_r == e_clear);
  assign wr_en       = w_v_i & (state_r == e_run);
  assign w_yumi_o    = wr_en;
  assign init_done_o = init_done_r;

  logic [lidx_width_p-1:0]  lidx_r, lidx_w;
  logic [gidx_width_p-1:0]  gidx_r, gidx_w;
  logic [cidx_width_p-1:0]  cidx_r, cidx_w;
  logic [lhist_width_p-1:0] lhist_rd;

  assign lidx_r   = r_addr_i[2+:lidx_width_p];
  assign gidx_r   = r_addr_i[2+:gidx_width_p] ^ gidx_width_p'(r_ghist_i);
  assign cidx_r   = r_addr_i[2+:cidx_width_p];
  assign lidx_w   = w_addr_i[2+:lidx_width_p];
  assign gidx_w   = w_addr_i[2+:gidx_width_p] ^ gidx_width_p'(w_ghist_i);
  assign cidx_w   = w_addr_i[2+:cidx_width_p];
  assign lhist_rd = lht[lidx_r];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{r_addr_i, w_addr_i};

  bp_fe_tourn_meta_s r_meta_r;
  logic              pred_v_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pred_v_r <= 1'b0;
      r_meta_r <= '0;
    end else begin
      pred_v_r <= r_v_i & (state_r == e_run);
      if (r_v_i && (state_r == e_run)) begin
        r_meta_r.lhist <= lhist_rd;
        r_meta_r.lctr  <= lpt[lhist_rd];
        r_meta_r.gctr  <= gpt[gidx_r];
        r_meta_r.cctr  <= cht[cidx_r];
      end
    end
  end

  assign pred_v_o = pred_v_r;
  assign r_meta_o = r_meta_r;
  assign pred_o   = r_meta_r.cctr[1] ? r_meta_r.gctr[1] : r_meta_r.lctr[1];

  bp_fe_tourn_meta_s w_meta;
  logic              w_lp, w_gp, w_chosen;
  logic [1:0]        lctr_next, gctr_next, cctr_next;

  assign w_meta   = w_meta_i;
  assign w_lp     = w_meta.lctr[1];
  assign w_gp     = w_meta.gctr[1];
  assign w_chosen = w_meta.cctr[1] ? w_gp : w_lp;

  bp_fe_sat_ctr2 lpt_sat (.ctr_i(w_meta.lctr), .up_i(w_taken_i),          .ctr_o(lctr_next));
  bp_fe_sat_ctr2 gpt_sat (.ctr_i(w_meta.gctr), .up_i(w_taken_i),          .ctr_o(gctr_next));
  bp_fe_sat_ctr2 cht_sat (.ctr_i(w_meta.cctr), .up_i(w_gp == w_taken_i), .ctr_o(cctr_next));

  // Training writes straight from returned metadata; reads in the same cycle see pre-write data.
  always_ff @(posedge clk_i) begin
    if (clearing) begin
      lht[idx_r[lidx_width_p-1:0]]  <= '0;
      lpt[idx_r[lhist_width_p-1:0]] <= ctr_init_gp;
      gpt[idx_r[gidx_width_p-1:0]]  <= ctr_init_gp;
      cht[idx_r[cidx_width_p-1:0]]  <= chooser_init_gp;
    end else if (wr_en) begin
      lht[lidx_w]       <= {w_meta.lhist[lhist_width_p-2:0], w_taken_i};
      lpt[w_meta.lhist] <= lctr_next;
      gpt[gidx_w]       <= gctr_next;
      if (w_lp != w_gp)
        cht[cidx_w] <= cctr_next;
    end
  end

`ifdef BP_FE_TOURN_STATS_EN
  logic [31:0] lmiss_r, gmiss_r, tmiss_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lmiss_r <= '0;
      gmiss_r <= '0;
      tmiss_r <= '0;
    end else if (wr_en) begin
      if (w_lp != w_taken_i)     lmiss_r <= lmiss_r + 32'd1;
      if (w_gp != w_taken_i)     gmiss_r <= gmiss_r + 32'd1;
      if (w_chosen != w_taken_i) tmiss_r <= tmiss_r + 32'd1;
    end
  end

  assign stat_lmiss_o = lmiss_r;
  assign stat_gmiss_o = gmiss_r;
  assign stat_tmiss_o = tmiss_r;
`else
  logic unused_chosen;
  assign unused_chosen = w_chosen;
  assign stat_lmiss_o  = '0;
  assign stat_gmiss_o  = '0;
  assign stat_tmiss_o  = '0;
`endif

endmodule

// File: tb/tb_bp_fe_tournament_bht.sv
// tb/tb_bp_fe_tournament_bht.sv - directed self-checking bench for bp_fe_tournament_bht
module tb_bp_fe_tournament_bht;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        init_done_o;
  logic        r_v_i;
  logic [38:0] r_addr_i;
  logic [7:0]  r_ghist_i;
  logic        pred_v_o;
  logic        pred_o;
  logic [13:0] r_meta_o;
  logic        w_v_i;
  logic [38:0] w_addr_i;
  logic [7:0]  w_ghist_i;
  logic [13:0] w_meta_i;
  logic        w_taken_i;
  logic        w_yumi_o;
  logic [31:0] stat_lmiss_o, stat_gmiss_o, stat_tmiss_o;

  int n_checks = 0;
  int n_errors = 0;
  logic yumi_seen, pv_seen;
  int   n_cyc;

`ifdef BP_FE_TOURN_STATS_EN
  localparam logic [31:0] exp_lmiss = 32'd2, exp_gmiss = 32'd3, exp_tmiss = 32'd3;
`else
  localparam logic [31:0] exp_lmiss = 32'd0, exp_gmiss = 32'd0, exp_tmiss = 32'd0;
`endif

  bp_fe_tournament_bht dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .init_done_o(init_done_o),
    .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_ghist_i(r_ghist_i),
    .pred_v_o(pred_v_o), .pred_o(pred_o), .r_meta_o(r_meta_o),
    .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_ghist_i(w_ghist_i),
    .w_meta_i(w_meta_i), .w_taken_i(w_taken_i), .w_yumi_o(w_yumi_o),
    .stat_lmiss_o(stat_lmiss_o), .stat_gmiss_o(stat_gmiss_o), .stat_tmiss_o(stat_tmiss_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk_meta(input logic [7:0] lh, input logic [1:0] l,
                                          input logic [1:0] g, input logic [1:0] c);
    return {lh, l, g, c};
  endfunction

  task automatic sweep_count(output int n);
    n = 0;
    while (!init_done_o && n < 1000) begin
      @(posedge clk_i);
      #1;
      n++;
      if (w_yumi_o && !init_done_o) yumi_seen = 1'b1;
      if (pred_v_o) pv_seen = 1'b1;
    end
  endtask

  task automatic set_read(input logic [38:0] a, input logic [7:0] gh);
    r_v_i = 1'b1; r_addr_i = a; r_ghist_i = gh;
  endtask

  task automatic set_write(input logic [38:0] a, input logic [7:0] gh,
                           input logic [13:0] m, input logic t);
    w_v_i = 1'b1; w_addr_i = a; w_ghist_i = gh; w_meta_i = m; w_taken_i = t;
  endtask

  task automatic do_read(input string tag, input logic [38:0] a, input logic [7:0] gh,
                         input logic exp_pred, input logic [13:0] exp_meta);
    @(negedge clk_i);
    set_read(a, gh);
    @(negedge clk_i);
    r_v_i = 1'b0;
    check_eq({tag, "_pred_v"}, 32'(pred_v_o), 32'd1);
    check_eq({tag, "_pred"},   32'(pred_o),   32'(exp_pred));
    check_eq({tag, "_meta"},   32'(r_meta_o), 32'(exp_meta));
  endtask

  task automatic do_write(input string tag, input logic [38:0] a, input logic [7:0] gh,
                          input logic [13:0] m, input logic t);
    @(negedge clk_i);
    set_write(a, gh, m, t);
    #1;
    check_eq({tag, "_yumi"}, 32'(w_yumi_o), 32'd1);
    @(negedge clk_i);
    w_v_i = 1'b0;
  endtask

  initial begin
    reset_n_i = 1'b0;
    r_v_i = 1'b0; r_addr_i = '0; r_ghist_i = '0;
    w_v_i = 1'b0; w_addr_i = '0; w_ghist_i = '0; w_meta_i = '0; w_taken_i = 1'b0;
    yumi_seen = 1'b0; pv_seen = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_init_done", 32'(init_done_o), 32'd0);
    check_eq("rst_pred_v",    32'(pred_v_o),    32'd0);
    check_eq("rst_pred",      32'(pred_o),      32'd0);
    check_eq("rst_meta",      32'(r_meta_o),    32'd0);
    check_eq("rst_yumi",      32'(w_yumi_o),    32'd0);

    // Hammer both ports through the sweep; neither may take effect.
    @(negedge clk_i);
    set_write(39'h80000000, 8'h00, mk_meta(8'h00, 2'b11, 2'b11, 2'b11), 1'b0);
    set_read(39'h80000000, 8'h00);
    reset_n_i = 1'b1;
    sweep_count(n_cyc);
    check_eq("init_cycles", 32'(n_cyc), 32'd512);
    check_eq("yumi_sweep",  32'(yumi_seen), 32'd0);
    check_eq("predv_sweep", 32'(pv_seen), 32'd0);
    @(negedge clk_i);
    w_v_i = 1'b0; r_v_i = 1'b0;

    do_read("rd0", 39'h80000000, 8'h00, 1'b0, mk_meta(8'h00, 2'b01, 2'b01, 2'b10));
    do_write("wr1", 39'h80000000, 8'h00, mk_meta(8'h00, 2'b01, 2'b01, 2'b10), 1'b1);
    do_read("rd1", 39'h80000000, 8'h00, 1'b1, mk_meta(8'h01, 2'b01, 2'b10, 2'b10));
    do_write("wr2", 39'h80000000, 8'h00, mk_meta(8'h01, 2'b01, 2'b10, 2'b10), 1'b1);
    do_read("rd2", 39'h80000000, 8'h00, 1'b1, mk_meta(8'h03, 2'b01, 2'b11, 2'b11));

    // lp=0, gp=1, not taken: chooser 10->01 so the next read follows local.
    do_write("wr3", 39'h80000104, 8'h00, mk_meta(8'h55, 2'b01, 2'b10, 2'b10), 1'b0);
    do_read("rd3", 39'h80000104, 8'h41, 1'b0, mk_meta(8'hAA, 2'b01, 2'b11, 2'b01));

    // Read and write of gidx 0 in the same cycle.
    @(negedge clk_i);
    set_read(39'h80000000, 8'h00);
    set_write(39'h80000000, 8'h00, mk_meta(8'h03, 2'b01, 2'b11, 2'b11), 1'b0);
    @(negedge clk_i);
    r_v_i = 1'b0; w_v_i = 1'b0;
    check_eq("rw_pred", 32'(pred_o),   32'd1);
    check_eq("rw_meta", 32'(r_meta_o), 32'(mk_meta(8'h03, 2'b01, 2'b11, 2'b11)));
    do_read("rd4", 39'h80000000, 8'h00, 1'b1, mk_meta(8'h06, 2'b01, 2'b10, 2'b10));

    check_eq("stat_lmiss", stat_lmiss_o, exp_lmiss);
    check_eq("stat_gmiss", stat_gmiss_o, exp_gmiss);
    check_eq("stat_tmiss", stat_tmiss_o, exp_tmiss);

    // Asynchronous reset between clock edges.
    @(posedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("arst_init_done", 32'(init_done_o), 32'd0);
    check_eq("arst_meta",      32'(r_meta_o),    32'd0);
    check_eq("arst_pred",      32'(pred_o),      32'd0);
    check_eq("arst_tmiss",     stat_tmiss_o,     32'd0);

    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (200) @(posedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("mid_init_done", 32'(init_done_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    sweep_count(n_cyc);
    check_eq("resweep_cycles", 32'(n_cyc), 32'd512);
    do_read("rd5", 39'h80000000, 8'h00, 1'b0, mk_meta(8'h00, 2'b01, 2'b01, 2'b10));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
